updown_ctrl: RTL and testbench
==============================

Name: updown_ctrl

Overview:
- Front-end control stage that sits directly upstream of the up/down modulus counter and drives its direction (u_d) and terminal-count (N) inputs.
- Takes raw, bouncy pushbuttons and slide switches from the board.
- Synchronises and debounces the buttons, toggles direction on each direction-button press, and loads a validated new modulus on each load-button press.
- Outputs are registered on posedge clk, so they are stable half a cycle before the counter's negedge sampling.

Parameters:
- WIDTH, 4: width of N and of the switch bus.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a debounced level changes. Must be ≥2. The board build overrides it to about 1,000,000.
- N_DEFAULT, 9: modulus value loaded at reset. Must be non-zero.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- btn_dir_raw  in  1  raw direction pushbutton, asynchronous to clk.
- btn_load_raw  in  1  raw load pushbutton, asynchronous to clk.
- n_sw  in  WIDTH  raw modulus switches, asynchronous to clk.
- u_d  out  1  count direction to the counter: 1 = up, 0 = down.
- N  out  WIDTH  terminal count to the counter.
- n_upd  out  1  one-cycle pulse when N has just been updated.
- n_err  out  1  one-cycle pulse when a load was rejected.

Behaviour:
- Reset values (asynchronous, active-high):
  - u_d=1, N=N_DEFAULT, n_upd=0, n_err=0.
  - All synchroniser flops 0, debounced levels 0, debounce counters 0, FSM=IDLE.
- Synchronisation:
  - Each button passes through a 2-flop synchroniser.
  - n_sw passes through a 2-flop synchroniser, one per bit (quasi-static input).
- Debounce, per button, with deb as the debounced level and cnt as the counter:
  - If sync==deb: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: deb<=sync and cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change in deb.
- Press pulse:
  - press = deb & ~deb_q, where deb_q is deb delayed one cycle. It is one cycle wide.
  - Releases generate nothing.
- Latency: if a raw rising edge is first captured at edge k and held, deb rises at edge k+1+DEBOUNCE_CYCLES. The resulting action (u_d toggle, or FSM leaving IDLE) occurs at edge k+2+DEBOUNCE_CYCLES.
- Direction: u_d <= ~u_d on each dir press. There is no other way u_d changes.
- Load FSM, encoded IDLE=0, CHECK=1, APPLY=2:
  - IDLE: on load press, n_cap <= synchronised n_sw and go to CHECK. Otherwise stay.
  - CHECK: if n_cap==0, pulse n_err and go to IDLE. Otherwise go to APPLY.
  - APPLY: N <= n_cap, pulse n_upd, go to IDLE.
  - A load press arriving while in CHECK or APPLY is dropped, not queued.
  - Loading a value equal to the current N still performs APPLY and pulses n_upd.
  - Illegal state: return to IDLE on the next edge.
- Simultaneous events: a dir press and a load press in the same cycle are both honoured independently.
- Reset mid-operation: a debounce in progress or an FSM in CHECK/APPLY is abandoned. N returns to N_DEFAULT and u_d to 1.
- Button held across reset release: because deb resets to 0, the button produces exactly one press DEBOUNCE_CYCLES+2 cycles after release. This is intended.
- n_upd and n_err are never high in the same cycle.

Decomposition:
- Shared package (include file): FSM state constants IDLE/CHECK/APPLY, WIDTH default, N_DEFAULT default.
- Sub-module btn_debounce (synchroniser, debounce counter, press edge detect; parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level, press), instantiated twice.
- The switch synchroniser and the FSM stay inline in updown_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, N_DEFAULT=9):
- Assert rst mid-simulation, with no clock edge -> u_d=1 and N=9 immediately; n_upd=n_err=0.
- btn_dir_raw high for 20 cycles, first captured at edge k -> u_d goes 1→0 at edge k+6 only; releasing it causes no change; a second press returns u_d to 1.
- btn_dir_raw with 3-cycle high glitches separated by 3-cycle lows, repeated 10 times -> u_d never changes.
- n_sw=4'd5, then load held 10 cycles -> n_upd pulses for exactly one cycle and N=5 at that edge; u_d unchanged.
- n_sw=4'd0, then load press -> n_err pulses for one cycle, N stays 9, n_upd stays 0.
- Dir and load raw edges in the same cycle with n_sw=4'd12 -> u_d toggles at edge k+6, N=12 two cycles later. Then assert rst while in CHECK -> N=9, u_d=1, no n_upd pulse.

Source files
------------

// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the updown_ctrl front-end stage:
// load FSM state encoding and default sizing parameters.
package updown_ctrl_pkg;

    // Load FSM states; encoding is fixed so a state probe reads 0/1/2.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        APPLY = 2'd2
    } load_state_t;

    localparam int WIDTH_DEF     = 4;
    localparam int N_DEFAULT_DEF = 9;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter and
// rising-edge press detect.
// Ports: clk, rst (async, active-high), raw (asynchronous button),
//        level (debounced level), press (one-cycle pulse per press).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1;
    logic          s2;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // The level only follows the input after it has differed from it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (s2 == deb) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= 1'b0;
        end else begin
            deb_q <= deb;
        end
    end

    assign level = deb;
    assign press = deb & ~deb_q;

endmodule

// File: rtl/updown_ctrl.sv
// Counter front-end: debounced direction toggle and validated modulus load.
// Ports: clk, rst (async, active-high), btn_dir_raw, btn_load_raw, n_sw
//        in; u_d (1=up), N (terminal count), n_upd / n_err pulses out.
module updown_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int N_DEFAULT       = N_DEFAULT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_dir_raw,
    input  logic             btn_load_raw,
    input  logic [WIDTH-1:0] n_sw,
    output logic             u_d,
    output logic [WIDTH-1:0] N,
    output logic             n_upd,
    output logic             n_err
);

    logic             dir_lvl;
    logic             dir_press;
    logic             ld_lvl;
    logic             ld_press;
    logic             unused_lvl;
    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;
    logic [WIDTH-1:0] n_cap;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] n_d;
    logic             upd_d;
    logic             err_d;
    load_state_t      state_q;
    load_state_t      state_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dir (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_dir_raw),
        .level(dir_lvl),
        .press(dir_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_load_raw),
        .level(ld_lvl),
        .press(ld_press)
    );

    // Only the press pulses drive behaviour; levels are kept for probing.
    assign unused_lvl = dir_lvl ^ ld_lvl;

    // Switches are quasi-static, so a per-bit synchroniser is enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= n_sw;
            sw_s2 <= sw_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_d <= 1'b1;
        end else if (dir_press) begin
            u_d <= ~u_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_cap   <= '0;
            N       <= WIDTH'(N_DEFAULT);
            n_upd   <= 1'b0;
            n_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_cap   <= cap_d;
            N       <= n_d;
            n_upd   <= upd_d;
            n_err   <= err_d;
        end
    end

    // Presses seen outside IDLE are dropped; a zero modulus is rejected.
    always_comb begin
        state_d = state_q;
        cap_d   = n_cap;
        n_d     = N;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_press) begin
                    cap_d   = sw_s2;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (n_cap == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                n_d     = n_cap;
                upd_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_updown_ctrl.sv
// Scoreboard bench for updown_ctrl: stimulus queues expected events
// (cycle and value), a negedge monitor pops and compares them.
module tb_updown_ctrl;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       btn_dir_raw;
    logic       btn_load_raw;
    logic [3:0] n_sw;
    logic       u_d;
    logic [3:0] N;
    logic       n_upd;
    logic       n_err;

    int  cyc;
    int  tests;
    int  fails;
    int  t0;
    logic prev_ud;
    ev_t dir_q[$];
    ev_t upd_q[$];
    ev_t err_q[$];

    updown_ctrl #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .N_DEFAULT      (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_dir_raw (btn_dir_raw),
        .btn_load_raw(btn_load_raw),
        .n_sw        (n_sw),
        .u_d         (u_d),
        .N           (N),
        .n_upd       (n_upd),
        .n_err       (n_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " u_d"}, int'(u_d), 1);
        chk({tag, " N"}, int'(N), 9);
        chk({tag, " n_upd"}, int'(n_upd), 0);
        chk({tag, " n_err"}, int'(n_err), 0);
    endtask

    // Monitor: any observed output event must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_ud = u_d;
        end else begin
            if (u_d !== prev_ud) begin
                if (dir_q.size() == 0) begin
                    chk("unexpected u_d change", int'(u_d), int'(prev_ud));
                end else begin
                    ev_t e;
                    e = dir_q.pop_front();
                    chk("dir toggle cycle", cyc, e.cyc);
                    chk("dir toggle value", int'(u_d), e.val);
                end
                prev_ud = u_d;
            end
            if (n_upd) begin
                if (upd_q.size() == 0) begin
                    chk("unexpected n_upd", 1, 0);
                end else begin
                    ev_t e;
                    e = upd_q.pop_front();
                    chk("n_upd cycle", cyc, e.cyc);
                    chk("n_upd N", int'(N), e.val);
                end
                chk("n_upd/n_err exclusive", int'(n_err), 0);
            end
            if (n_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected n_err", 1, 0);
                end else begin
                    ev_t e;
                    e = err_q.pop_front();
                    chk("n_err cycle", cyc, e.cyc);
                    chk("n_err N kept", int'(N), e.val);
                end
            end
        end
    end

    // Drive at a negedge: first capture edge k = cyc+1, so the u_d toggle
    // lands at k+6, n_err at k+7 and n_upd at k+8.
    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        btn_dir_raw  = 1'b0;
        btn_load_raw = 1'b0;
        n_sw         = 4'd0;
        prev_ud      = 1'b1;
        wait_cyc(3);
        chk_reset("reset");
        #1 rst = 1'b0;
        wait_cyc(3);

        // Direction press held 20 cycles, then a second press.
        btn_dir_raw = 1'b1;
        dir_q.push_back('{cyc + 7, 0});
        wait_cyc(20);
        btn_dir_raw = 1'b0;
        wait_cyc(12);
        btn_dir_raw = 1'b1;
        dir_q.push_back('{cyc + 7, 1});
        wait_cyc(10);
        btn_dir_raw = 1'b0;
        wait_cyc(12);

        // Short glitches never reach the debounced level.
        for (int i = 0; i < 10; i++) begin
            btn_dir_raw = 1'b1;
            wait_cyc(3);
            btn_dir_raw = 1'b0;
            wait_cyc(3);
        end
        wait_cyc(10);

        // Valid load of 5.
        n_sw = 4'd5;
        wait_cyc(3);
        btn_load_raw = 1'b1;
        upd_q.push_back('{cyc + 9, 5});
        wait_cyc(10);
        btn_load_raw = 1'b0;
        wait_cyc(12);

        // Zero load is rejected; N keeps 5.
        n_sw = 4'd0;
        wait_cyc(3);
        btn_load_raw = 1'b1;
        err_q.push_back('{cyc + 8, 5});
        wait_cyc(10);
        btn_load_raw = 1'b0;
        wait_cyc(12);

        // Move u_d to 0, then reset between clock edges.
        btn_dir_raw = 1'b1;
        dir_q.push_back('{cyc + 7, 0});
        wait_cyc(10);
        btn_dir_raw = 1'b0;
        wait_cyc(12);
        chk("pre-reset u_d", int'(u_d), 0);
        #1 rst = 1'b1;
        #1 chk_reset("async reset");
        wait_cyc(2);
        #1 rst = 1'b0;
        wait_cyc(3);

        // Simultaneous dir and load presses with 12 on the switches.
        n_sw = 4'd12;
        wait_cyc(3);
        btn_dir_raw  = 1'b1;
        btn_load_raw = 1'b1;
        dir_q.push_back('{cyc + 7, 0});
        upd_q.push_back('{cyc + 9, 12});
        wait_cyc(10);
        btn_dir_raw  = 1'b0;
        btn_load_raw = 1'b0;
        wait_cyc(12);
        chk("N after 12 load", int'(N), 12);

        // Reset while the FSM sits in CHECK abandons the load.
        n_sw = 4'd3;
        wait_cyc(3);
        btn_load_raw = 1'b1;
        t0 = cyc;
        wait_cyc(7);
        chk("in CHECK window", cyc - t0, 7);
        #1 rst = 1'b1;
        btn_load_raw = 1'b0;
        #1 chk_reset("reset in CHECK");
        wait_cyc(2);
        #1 rst = 1'b0;
        wait_cyc(20);
        chk("N after abandoned load", int'(N), 9);

        chk("dir events left", dir_q.size(), 0);
        chk("upd events left", upd_q.size(), 0);
        chk("err events left", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
